booth_mult: RTL

//   Multicycle signed multiplier (radix-2 Booth) for the MULT instruction.

---
 rtl/booth_mult.sv | 98 +++++++++
 1 files changed

// File: rtl/booth_mult.sv
// Multicycle signed radix-2 Booth multiplier: one Booth step per clock,
// 2*WIDTH-bit product held in hi/lo until the next accepted start.
module booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q1_reg;
    logic [WIDTH:0]   m_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    logic [WIDTH:0]   a_sum;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;

    // A and M carry one extra sign bit so M = -2^(WIDTH-1) cannot overflow A.
    always_comb begin
        a_sum = a_reg;
        case ({q_reg[0], q1_reg})
            2'b01:   a_sum = a_reg + m_reg;
            2'b10:   a_sum = a_reg - m_reg;
            default: a_sum = a_reg;
        endcase
        a_next = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_next = {a_sum[0], q_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            q_reg     <= '0;
            q1_reg    <= 1'b0;
            m_reg     <= '0;
            count_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= '0;
                        q_reg     <= multiplier;
                        q1_reg    <= 1'b0;
                        m_reg     <= {multiplicand[WIDTH-1], multiplicand};
                        count_reg <= CW'(WIDTH);
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_reg     <= a_next;
                    q_reg     <= q_next;
                    q1_reg    <= q_reg[0];
                    count_reg <= count_reg - CW'(1);
                    // Last step: publish the shifted result directly so hi/lo
                    // only ever change on this edge.
                    if (count_reg == CW'(1)) begin
                        hi_reg    <= a_next[WIDTH-1:0];
                        lo_reg    <= q_next;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign hi   = hi_reg;
    assign lo   = lo_reg;
    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

endmodule
